// File: rtl/pipeline_stall_controller_if.sv
// Freeze/flush control bundle between the pipeline stall controller and the
// hazard unit, EXE branch logic, MEM handshake and pipeline registers.
// Handshake semantics: mem_req marks a valid MEM-stage access; the access
// completes in the cycle mem_ready is high. A cycle with mem_req=1 and
// mem_ready=0 is a stall cycle. There is no backpressure on the control
// outputs; they are combinational and take effect in the current cycle.
interface pipeline_stall_controller_if #(
  parameter int WAIT_W = 8,
  parameter int CNT_W  = 16
);
  logic              hazard_detected;
  logic              branch_taken;
  logic              mem_req;
  logic              mem_ready;
  logic              clr_stats;
  logic              freeze_if;
  logic              freeze_id;
  logic              freeze_exe;
  logic              freeze_mem;
  logic              flush_if_id;
  logic              flush_id_exe;
  logic              wb_bubble;
  logic              busy;
  logic              mem_timeout;
  logic [CNT_W-1:0]  stall_cycles;
  logic [CNT_W-1:0]  flush_events;
  // Debug visibility of the FSM: 0=RUN, 1=MEM_WAIT, 2=ERROR
  logic [1:0]        dbg_state;
  logic [WAIT_W-1:0] dbg_wait_cnt;

  // Controller side
  modport slave (
    input  hazard_detected, branch_taken, mem_req, mem_ready, clr_stats,
    output freeze_if, freeze_id, freeze_exe, freeze_mem,
    output flush_if_id, flush_id_exe, wb_bubble,
    output busy, mem_timeout, stall_cycles, flush_events,
    output dbg_state, dbg_wait_cnt
  );

  // Pipeline / environment side
  modport master (
    output hazard_detected, branch_taken, mem_req, mem_ready, clr_stats,
    input  freeze_if, freeze_id, freeze_exe, freeze_mem,
    input  flush_if_id, flush_id_exe, wb_bubble,
    input  busy, mem_timeout, stall_cycles, flush_events,
    input  dbg_state, dbg_wait_cnt
  );
endinterface

// File: rtl/pipeline_stall_controller.sv
// Central freeze/flush sequencer for the five-stage pipeline. Combines the
// hazard unit, EXE branch decision and MEM handshake into per-stage freeze
// and flush controls, runs the memory-wait FSM with a timeout watchdog and
// keeps saturating stall/flush statistics.
module pipeline_stall_controller #(
  parameter int TIMEOUT = 255,
  parameter int WAIT_W  = 8,
  parameter int CNT_W   = 16
) (
  input logic                    clk,
  input logic                    rst,
  pipeline_stall_controller_if.slave bus
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } state_t;

  localparam logic [WAIT_W-1:0] TIMEOUT_C = WAIT_W'(TIMEOUT);

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0]  stall_q, stall_d;
  logic [CNT_W-1:0]  flush_q, flush_d;

  logic freeze_if, freeze_id, freeze_exe, freeze_mem;
  logic flush_if_id, flush_id_exe, wb_bubble;
  logic run_mode;

  // State register for the memory-wait FSM and its wait counter
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Next state plus Mealy freeze/flush decode; memory stall outranks branch/hazard
  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    run_mode     = 1'b0;
    freeze_if    = 1'b0;
    freeze_id    = 1'b0;
    freeze_exe   = 1'b0;
    freeze_mem   = 1'b0;
    flush_if_id  = 1'b0;
    flush_id_exe = 1'b0;
    wb_bubble    = 1'b0;

    case (state_q)
      RUN: begin
        if (bus.mem_req && !bus.mem_ready) begin
          freeze_if  = 1'b1;
          freeze_id  = 1'b1;
          freeze_exe = 1'b1;
          freeze_mem = 1'b1;
          wb_bubble  = 1'b1;
          state_d    = MEM_WAIT;
          wait_cnt_d = WAIT_W'(1);
        end else begin
          run_mode = 1'b1;
        end
      end
      MEM_WAIT: begin
        // mem_req is not consulted: the stalled access is still in MEM
        if (!bus.mem_ready) begin
          freeze_if  = 1'b1;
          freeze_id  = 1'b1;
          freeze_exe = 1'b1;
          freeze_mem = 1'b1;
          wb_bubble  = 1'b1;
          if (wait_cnt_q == TIMEOUT_C) begin
            state_d = ERROR;
          end else begin
            wait_cnt_d = wait_cnt_q + WAIT_W'(1);
          end
        end else begin
          // Release cycle: a branch or hazard held during the wait acts now
          run_mode   = 1'b1;
          state_d    = RUN;
          wait_cnt_d = '0;
        end
      end
      ERROR: begin
        // Dead-locked memory: hold the whole pipeline until reset
        freeze_if  = 1'b1;
        freeze_id  = 1'b1;
        freeze_exe = 1'b1;
        freeze_mem = 1'b1;
        wb_bubble  = 1'b1;
      end
      default: begin
        state_d    = RUN;
        wait_cnt_d = '0;
      end
    endcase

    if (run_mode) begin
      if (bus.branch_taken) begin
        flush_if_id  = 1'b1;
        flush_id_exe = 1'b1;
      end else if (bus.hazard_detected) begin
        freeze_if    = 1'b1;
        freeze_id    = 1'b1;
        flush_id_exe = 1'b1;
      end
    end
  end

  // Saturating statistics; clear outranks a same-cycle increment
  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    if (bus.clr_stats) begin
      stall_d = '0;
      flush_d = '0;
    end else begin
      if (freeze_if && (stall_q != {CNT_W{1'b1}})) begin
        stall_d = stall_q + CNT_W'(1);
      end
      if (flush_if_id && (flush_q != {CNT_W{1'b1}})) begin
        flush_d = flush_q + CNT_W'(1);
      end
    end
  end

  // Statistics registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign bus.freeze_if    = freeze_if;
  assign bus.freeze_id    = freeze_id;
  assign bus.freeze_exe   = freeze_exe;
  assign bus.freeze_mem   = freeze_mem;
  assign bus.flush_if_id  = flush_if_id;
  assign bus.flush_id_exe = flush_id_exe;
  assign bus.wb_bubble    = wb_bubble;
  assign bus.busy         = (state_q == MEM_WAIT);
  assign bus.mem_timeout  = (state_q == ERROR);
  assign bus.stall_cycles = stall_q;
  assign bus.flush_events = flush_q;
  assign bus.dbg_state    = state_q;
  assign bus.dbg_wait_cnt = wait_cnt_q;

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Directed bench for pipeline_stall_controller with TIMEOUT=4, CNT_W=4.
module tb_pipeline_stall_controller;

  localparam int TIMEOUT = 4;
  localparam int WAIT_W  = 8;
  localparam int CNT_W   = 4;

  // {freeze_if, freeze_id, freeze_exe, freeze_mem, flush_if_id, flush_id_exe, wb_bubble}
  localparam logic [6:0] C_IDLE   = 7'b0000000;
  localparam logic [6:0] C_HAZARD = 7'b1100010;
  localparam logic [6:0] C_BRANCH = 7'b0000110;
  localparam logic [6:0] C_FROZEN = 7'b1111001;

  logic clk;
  logic rst;
  int   compares;
  int   errors;
  int   n;

  pipeline_stall_controller_if #(.WAIT_W(WAIT_W), .CNT_W(CNT_W)) bus ();

  pipeline_stall_controller #(
    .TIMEOUT(TIMEOUT),
    .WAIT_W (WAIT_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  // Clock and reset defaults
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] ctrl();
    return {bus.freeze_if, bus.freeze_id, bus.freeze_exe, bus.freeze_mem,
            bus.flush_if_id, bus.flush_id_exe, bus.wb_bubble};
  endfunction

  // Driver tasks: inputs change 1 ns after the rising edge, checks follow #2 later
  task automatic drive(input logic h, input logic b, input logic rq,
                       input logic rd, input logic clr);
    bus.hazard_detected = h;
    bus.branch_taken    = b;
    bus.mem_req         = rq;
    bus.mem_ready       = rd;
    bus.clr_stats       = clr;
    #2;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    compares++;
    if (ctrl() !== C_IDLE) begin
      errors++; $display("FAIL reset_ctrl: got %b expected %b", ctrl(), C_IDLE);
    end
    compares++;
    if (bus.busy !== 1'b0 || bus.mem_timeout !== 1'b0) begin
      errors++; $display("FAIL reset_status: got busy=%b timeout=%b expected 0/0", bus.busy, bus.mem_timeout);
    end
    compares++;
    if (bus.stall_cycles !== 4'd0 || bus.flush_events !== 4'd0) begin
      errors++; $display("FAIL reset_counters: got %0d/%0d expected 0/0", bus.stall_cycles, bus.flush_events);
    end
    compares++;
    if (bus.dbg_state !== 2'd0 || bus.dbg_wait_cnt !== 8'd0) begin
      errors++; $display("FAIL reset_fsm: got state=%0d wait=%0d expected 0/0", bus.dbg_state, bus.dbg_wait_cnt);
    end
    tick();
  endtask

  task automatic test_hazard_branch();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    compares++;
    if (ctrl() !== C_HAZARD) begin
      errors++; $display("FAIL hazard_ctrl: got %b expected %b", ctrl(), C_HAZARD);
    end
    tick();
    compares++;
    if (bus.stall_cycles !== 4'd1 || bus.flush_events !== 4'd0) begin
      errors++; $display("FAIL hazard_counters: got %0d/%0d expected 1/0", bus.stall_cycles, bus.flush_events);
    end
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    compares++;
    if (ctrl() !== C_BRANCH) begin
      errors++; $display("FAIL branch_priority_ctrl: got %b expected %b", ctrl(), C_BRANCH);
    end
    tick();
    compares++;
    if (bus.stall_cycles !== 4'd1 || bus.flush_events !== 4'd1) begin
      errors++; $display("FAIL branch_counters: got %0d/%0d expected 1/1", bus.stall_cycles, bus.flush_events);
    end
    // Access completing in its first cycle does not stall
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    compares++;
    if (ctrl() !== C_IDLE) begin
      errors++; $display("FAIL mem_hit_ctrl: got %b expected %b", ctrl(), C_IDLE);
    end
    tick();
    compares++;
    if (bus.busy !== 1'b0) begin
      errors++; $display("FAIL mem_hit_busy: got %b expected 0", bus.busy);
    end
  endtask

  task automatic test_mem_wait();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 3; i++) begin
      compares++;
      if (ctrl() !== C_FROZEN || bus.busy !== (i > 1)) begin
        errors++; $display("FAIL mem_wait_c%0d: got ctrl=%b busy=%b expected %b busy=%b", i, ctrl(), bus.busy, C_FROZEN, (i > 1));
      end
      tick();
    end
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    compares++;
    if (ctrl() !== C_BRANCH || bus.busy !== 1'b1) begin
      errors++; $display("FAIL mem_release: got ctrl=%b busy=%b expected %b busy=1", ctrl(), bus.busy, C_BRANCH);
    end
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    compares++;
    if (bus.busy !== 1'b0 || bus.stall_cycles !== 4'd3 || bus.flush_events !== 4'd1) begin
      errors++; $display("FAIL mem_after: got busy=%b stall=%0d flush=%0d expected 0/3/1", bus.busy, bus.stall_cycles, bus.flush_events);
    end
    // Hazard held across a one-cycle wait is applied on release
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    compares++;
    if (ctrl() !== C_FROZEN) begin
      errors++; $display("FAIL wait_hazard_entry: got %b expected %b", ctrl(), C_FROZEN);
    end
    tick();
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    compares++;
    if (ctrl() !== C_HAZARD) begin
      errors++; $display("FAIL wait_hazard_release: got %b expected %b", ctrl(), C_HAZARD);
    end
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    compares++;
    if (bus.busy !== 1'b0 || bus.stall_cycles !== 4'd5) begin
      errors++; $display("FAIL wait_hazard_after: got busy=%b stall=%0d expected 0/5", bus.busy, bus.stall_cycles);
    end
  endtask

  task automatic test_timeout();
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= TIMEOUT + 1; i++) begin
      compares++;
      if (ctrl() !== C_FROZEN || bus.mem_timeout !== 1'b0 || bus.busy !== (i > 1)) begin
        errors++; $display("FAIL timeout_c%0d: got ctrl=%b timeout=%b busy=%b expected %b 0 %b", i, ctrl(), bus.mem_timeout, bus.busy, C_FROZEN, (i > 1));
      end
      tick();
    end
    compares++;
    if (bus.mem_timeout !== 1'b1 || bus.busy !== 1'b0 || ctrl() !== C_FROZEN) begin
      errors++; $display("FAIL timeout_error: got timeout=%b busy=%b ctrl=%b expected 1 0 %b", bus.mem_timeout, bus.busy, ctrl(), C_FROZEN);
    end
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    compares++;
    if (ctrl() !== C_FROZEN) begin
      errors++; $display("FAIL error_ignores_ready: got %b expected %b", ctrl(), C_FROZEN);
    end
    tick();
    compares++;
    if (bus.mem_timeout !== 1'b1) begin
      errors++; $display("FAIL error_sticky: got %b expected 1", bus.mem_timeout);
    end
    rst = 1'b0;
    tick();
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    compares++;
    if (bus.mem_timeout !== 1'b0 || bus.busy !== 1'b0 || ctrl() !== C_IDLE || bus.stall_cycles !== 4'd0) begin
      errors++; $display("FAIL error_reset: got timeout=%b busy=%b ctrl=%b stall=%0d expected 0 0 %b 0", bus.mem_timeout, bus.busy, ctrl(), C_IDLE, bus.stall_cycles);
    end
    tick();
  endtask

  task automatic test_saturation();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (i == 14 || i == 20) begin
        compares++;
        if (bus.stall_cycles !== ((i < 15) ? 4'(i) : 4'd15)) begin
          errors++; $display("FAIL sat_c%0d: got %0d expected %0d", i, bus.stall_cycles, (i < 15) ? i : 15);
        end
      end
    end
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    compares++;
    if (bus.stall_cycles !== 4'd0) begin
      errors++; $display("FAIL clr_wins: got %0d expected 0", bus.stall_cycles);
    end
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    compares++;
    if (bus.stall_cycles !== 4'd1 || bus.flush_events !== 4'd0) begin
      errors++; $display("FAIL count_resume: got %0d/%0d expected 1/0", bus.stall_cycles, bus.flush_events);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_wait();
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    tick();
    compares++;
    if (bus.busy !== 1'b1 || bus.dbg_wait_cnt !== 8'd2) begin
      errors++; $display("FAIL mid_wait_pre: got busy=%b wait=%0d expected 1/2", bus.busy, bus.dbg_wait_cnt);
    end
    rst = 1'b0;
    tick();
    rst = 1'b1;
    #2;
    compares++;
    if (bus.busy !== 1'b0 || bus.dbg_wait_cnt !== 8'd0 || bus.dbg_state !== 2'd0) begin
      errors++; $display("FAIL mid_wait_reset: got busy=%b wait=%0d state=%0d expected 0/0/0", bus.busy, bus.dbg_wait_cnt, bus.dbg_state);
    end
    n = 0;
    while (bus.mem_timeout !== 1'b1 && n < 20) begin
      n++;
      tick();
      #2;
    end
    compares++;
    if (n !== TIMEOUT + 1) begin
      errors++; $display("FAIL mid_wait_restart: got %0d cycles to timeout expected %0d", n, TIMEOUT + 1);
    end
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    rst = 1'b1;
  endtask

  // Test sequence and final report
  initial begin
    compares = 0;
    errors   = 0;
    rst      = 1'b0;
    bus.hazard_detected = 1'b0;
    bus.branch_taken    = 1'b0;
    bus.mem_req         = 1'b0;
    bus.mem_ready       = 1'b0;
    bus.clr_stats       = 1'b0;
    tick();
    test_reset();
    test_hazard_branch();
    test_mem_wait();
    test_timeout();
    test_saturation();
    test_reset_mid_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, errors);
    $finish;
  end

endmodule
